// File: rtl/npc_pkg.sv
// Shared constants, state encoding and address-range helper for the
// instruction SRAM responder and its neighbours.
package npc_pkg;

    localparam logic [1:0]  RRESP_OKAY   = 2'b00;
    localparam logic [1:0]  RRESP_SLVERR = 2'b10;
    localparam logic [31:0] RESET_PC     = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } isram_state_e;

    // 33-bit compare so that a window ending at the top of memory never wraps.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input int unsigned depth_log2);
        logic [32:0] off;
        logic [32:0] span;
        off  = {1'b0, addr} - {1'b0, base};
        span = 33'd4 << depth_log2;
        return (addr[1:0] == 2'b00) && (addr >= base) && (off < span);
    endfunction

endpackage

// File: rtl/isram_lfsr.sv
// 4-bit Fibonacci LFSR (x^4 + x^3 + 1), seeded with 4'b1001 on reset and
// stepped once per enable cycle.
module isram_lfsr (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [3:0] q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= 4'b1001;
        else if (en)
            q <= {q[2:0], q[3] ^ q[2]};
    end

endmodule

// File: rtl/isram_resp.sv
// Instruction SRAM with a single-outstanding AXI-style read responder and a
// loader write port. ISRAM_RAND_DELAY_EN adds 0..3 random extra wait cycles.
module isram_resp
    import npc_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned LATENCY    = 2,
    parameter logic [31:0] BASE_ADDR  = RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic        wen,
    input  logic [31:0] waddr,
    input  logic [31:0] wdata
);

    localparam int unsigned WORDS = 1 << DEPTH_LOG2;

    logic [31:0]           mem [WORDS];
    isram_state_e          state, state_nxt;
    logic [4:0]            cnt, cnt_nxt, load_val;
    logic [31:0]           addr_q, rd_addr, rd_word;
    logic [DEPTH_LOG2-1:0] rd_idx, wr_idx;
    logic                  accept, sample, rd_ok, wr_ok;

    assign arready = (state == ST_IDLE);
    assign rvalid  = (state == ST_RESP);
    assign accept  = arvalid && arready;

`ifdef ISRAM_RAND_DELAY_EN
    logic [3:0] lfsr;

    isram_lfsr u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (accept),
        .q   (lfsr)
    );

    assign load_val = 5'(LATENCY) + {3'b000, lfsr[1:0]};
`else
    assign load_val = 5'(LATENCY);
`endif

    // A zero-latency accept samples the array straight from araddr.
    assign rd_addr = (state == ST_IDLE) ? araddr : addr_q;
    assign rd_ok   = addr_in_range(rd_addr, BASE_ADDR, DEPTH_LOG2);
    assign rd_idx  = DEPTH_LOG2'((rd_addr - BASE_ADDR) >> 2);
    assign wr_ok   = wen && addr_in_range(waddr, BASE_ADDR, DEPTH_LOG2);
    assign wr_idx  = DEPTH_LOG2'((waddr - BASE_ADDR) >> 2);

    // Forward a same-cycle write so a load landing on the sampling edge is seen.
    assign rd_word = (wr_ok && waddr == rd_addr) ? wdata : mem[rd_idx];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sample    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    cnt_nxt = load_val;
                    if (load_val == 5'd0) begin
                        state_nxt = ST_RESP;
                        sample    = 1'b1;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_nxt = cnt - 5'd1;
                if (cnt == 5'd1) begin
                    state_nxt = ST_RESP;
                    sample    = 1'b1;
                end
            end
            ST_RESP: begin
                if (rready)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            addr_q <= '0;
            rdata  <= '0;
            rresp  <= RRESP_OKAY;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept)
                addr_q <= araddr;
            if (sample) begin
                rdata <= rd_ok ? rd_word : 32'h0;
                rresp <= rd_ok ? RRESP_OKAY : RRESP_SLVERR;
            end
        end
    end

    // Array deliberately has no reset; program contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_idx] <= wdata;
    end

endmodule

// File: tb/tb_isram_resp.sv
// Self-checking bench for isram_resp: a LATENCY=2 instance driven from a
// vector table through a scoreboard, plus a LATENCY=0 instance.
module tb_isram_resp;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] araddr = '0, waddr = '0, wdata = '0;
    logic        arvalid = 1'b0, rready = 1'b0, wen = 1'b0;
    logic        arready, rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    logic [31:0] araddr0 = '0;
    logic        arvalid0 = 1'b0, rready0 = 1'b0;
    logic        arready0, rvalid0;
    logic [31:0] rdata0;
    logic [1:0]  rresp0;

    always #5 clk = ~clk;

    isram_resp #(.LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .wen(wen), .waddr(waddr), .wdata(wdata)
    );

    isram_resp #(.LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .araddr(araddr0), .arvalid(arvalid0), .arready(arready0),
        .rdata(rdata0), .rresp(rresp0), .rvalid(rvalid0), .rready(rready0),
        .wen(wen), .waddr(waddr), .wdata(wdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  resp;
        logic [31:0] data;
        int          hold;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    vec_t       vecs[8];
    exp_t       sb[$];
    exp_t       sb0[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] lfsr_m  = 4'b1001;
    logic [3:0] lfsr0_m = 4'b1001;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        wen = 1'b1; waddr = a; wdata = d;
        @(negedge clk);
        wen = 1'b0;
    endtask

    // wr_wait: write wv to the fetched address during the first WAIT cycle.
    // wr_resp: write wv to it during the first held RESP cycle.
    task automatic fetch(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er,
                         input int hold, input logic wr_wait, input logic wr_resp,
                         input logic [31:0] wv);
        int   lat, elat;
        exp_t e;
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        chk("arready_idle", arready, 1);
        sb.push_back('{ed, er});
`ifdef ISRAM_RAND_DELAY_EN
        elat   = LAT + 1 + int'(lfsr_m[1:0]);
        lfsr_m = {lfsr_m[2:0], lfsr_m[3] ^ lfsr_m[2]};
`else
        elat = LAT + 1;
`endif
        @(negedge clk);
        // A stray request while busy must be ignored.
        araddr = 32'h8000_000C;
        if (wr_wait) begin
            wen = 1'b1; waddr = a; wdata = wv;
        end
        lat = 1;
        while (!rvalid && lat < 40) begin
            chk("arready_wait", arready, 0);
            @(negedge clk);
            wen = 1'b0;
            lat++;
        end
        wen = 1'b0;
        chk("latency", lat, elat);
        e = sb.pop_front();
        for (int i = 0; i < hold; i++) begin
            chk("hold_rvalid", rvalid, 1);
            chk("hold_rdata", rdata, e.data);
            chk("hold_rresp", rresp, e.resp);
            chk("hold_arready", arready, 0);
            if (wr_resp && i == 0) begin
                wen = 1'b1; waddr = a; wdata = wv;
            end
            @(negedge clk);
            wen = 1'b0;
        end
        chk("rvalid", rvalid, 1);
        chk("rdata", rdata, e.data);
        chk("rresp", rresp, e.resp);
        rready = 1'b1; arvalid = 1'b0;
        @(negedge clk);
        rready = 1'b0;
        chk("arready_after", arready, 1);
        chk("rvalid_after", rvalid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int   lat;
        logic seen;
        exp_t e;

        vecs[0] = '{32'h8000_0000, 2'b00, 32'h0000_0413, 0};
        vecs[1] = '{32'h8000_0004, 2'b00, 32'h1111_2222, 5};
        vecs[2] = '{32'h8000_3FFC, 2'b00, 32'hDEAD_BEEF, 1};
        vecs[3] = '{32'h8000_0002, 2'b10, 32'h0000_0000, 0};
        vecs[4] = '{32'h7FFF_FFFC, 2'b10, 32'h0000_0000, 2};
        vecs[5] = '{32'h8000_4000, 2'b10, 32'h0000_0000, 0};
        vecs[6] = '{32'hFFFF_FFFC, 2'b10, 32'h0000_0000, 0};
        vecs[7] = '{32'h8000_0008, 2'b00, 32'hA5A5_5A5A, 3};

        repeat (2) @(negedge clk);
        chk("rst_arready", arready, 1);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_rresp", rresp, 2'b00);
        chk("rst_arready0", arready0, 1);
        rst = 1'b0;

        load(32'h8000_0000, 32'h0000_0413);
        load(32'h8000_0004, 32'h1111_2222);
        load(32'h8000_0008, 32'hA5A5_5A5A);
        load(32'h8000_000C, 32'h0C0C_0C0C);
        load(32'h8000_0010, 32'h0000_0010);
        load(32'h8000_3FFC, 32'hDEAD_BEEF);
        // Writes below must be dropped; each would alias onto a tabled word.
        load(32'h8000_0006, 32'hFFFF_FFFF);
        load(32'h8000_4000, 32'h0BAD_0BAD);
        load(32'h7FFF_FFFC, 32'h0BAD_FFFC);

        for (int i = 0; i < 8; i++)
            fetch(vecs[i].addr, vecs[i].data, vecs[i].resp, vecs[i].hold, 1'b0, 1'b0, 32'h0);

        fetch(32'h8000_0010, 32'h1234_5678, 2'b00, 0, 1'b1, 1'b0, 32'h1234_5678);
        fetch(32'h8000_0010, 32'h1234_5678, 2'b00, 3, 1'b0, 1'b1, 32'h8765_4321);
        fetch(32'h8000_0010, 32'h8765_4321, 2'b00, 0, 1'b0, 1'b0, 32'h0);

        // LATENCY=0 instance: back-to-back fetches with rready held high.
        rready0 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            int elat0;
            @(negedge clk);
            araddr0 = 32'h8000_0000 + 32'(k * 4); arvalid0 = 1'b1;
            chk("arready0_idle", arready0, 1);
            sb0.push_back('{(k == 0) ? 32'h0000_0413 : 32'h1111_2222, 2'b00});
`ifdef ISRAM_RAND_DELAY_EN
            elat0   = 1 + int'(lfsr0_m[1:0]);
            lfsr0_m = {lfsr0_m[2:0], lfsr0_m[3] ^ lfsr0_m[2]};
`else
            elat0 = 1;
`endif
            @(negedge clk);
            arvalid0 = 1'b0;
            lat = 1;
            while (!rvalid0 && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            chk("latency0", lat, elat0);
            e = sb0.pop_front();
            chk("rdata0", rdata0, e.data);
            chk("rresp0", rresp0, e.resp);
        end
        @(negedge clk);
        rready0 = 1'b0;
        chk("arready0_after", arready0, 1);

        // Reset one cycle into WAIT abandons the request.
        @(negedge clk);
        araddr = 32'h8000_0000; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; rready = 1'b1;
        lfsr_m = 4'b1001; lfsr0_m = 4'b1001;
        chk("rstwait_arready", arready, 1);
        chk("rstwait_rvalid", rvalid, 0);
        chk("rstwait_rdata", rdata, 32'h0);
        chk("rstwait_rresp", rresp, 2'b00);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rvalid) seen = 1'b1;
        end
        rready = 1'b0;
        chk("rstwait_no_resp", seen, 0);

        fetch(32'h8000_0000, 32'h0000_0413, 2'b00, 0, 1'b0, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
